// File: rtl/alarm_ctrl.sv
// Alarm controller: compares the running hh:mm:ss against a programmable alarm and drives ring/snoozed.
// Latency: ring/snoozed/readback are registered, one cycle after the triggering input cycle.
// Backpressure: none; snooze/stop/set_en are single-cycle pulses consumed in the cycle presented.
//
// Ports:
//   clk, rst (synchronous, active-low)
//   seconds/minutes/hours : running time from the time counter
//   alarm_on              : arm level
//   set_en/set_hours/set_minutes : load alarm time (loaded as given, no range check)
//   snooze, stop          : control pulses
//   ring, snoozed         : registered state indications
//   alarm_hours/alarm_minutes : alarm time readback
// Optional: define SNOOZE_LIMIT_EN to cap snoozes per alarm event at MAX_SNOOZE.
module alarm_ctrl #(
  parameter int SNOOZE_MIN     = 5,
  parameter int RING_TIMEOUT_S = 60
`ifdef SNOOZE_LIMIT_EN
  , parameter int MAX_SNOOZE   = 3
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] seconds,
  input  logic [5:0] minutes,
  input  logic [4:0] hours,
  input  logic       alarm_on,
  input  logic       set_en,
  input  logic [4:0] set_hours,
  input  logic [5:0] set_minutes,
  input  logic       snooze,
  input  logic       stop,
  output logic       ring,
  output logic       snoozed,
  output logic [4:0] alarm_hours,
  output logic [5:0] alarm_minutes
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] sec_q;
  logic [4:0] al_hr_q, al_hr_d;
  logic [5:0] al_min_q, al_min_d;
  logic [4:0] tgt_hr_q, tgt_hr_d;
  logic [5:0] tgt_min_q, tgt_min_d;
  logic [7:0] ring_cnt_q, ring_cnt_d;
  logic       ring_q, snoozed_q;

  logic       sec_edge;
  logic       hit_alarm;
  logic       hit_tgt;
  logic       snooze_ok;
  logic [6:0] snz_sum;

  // Only the second change into :00 counts, so a time held at hh:mm:00 fires once.
  assign sec_edge  = (seconds != sec_q);
  assign hit_alarm = sec_edge && (seconds == 6'd0) && (hours == al_hr_q) && (minutes == al_min_q);
  assign hit_tgt   = sec_edge && (seconds == 6'd0) && (hours == tgt_hr_q) && (minutes == tgt_min_q);

  // 7-bit add so the carry past 59 is visible before the wrap compare.
  assign snz_sum = {1'b0, minutes} + 7'(SNOOZE_MIN);

`ifdef SNOOZE_LIMIT_EN
  localparam int SCW = ($clog2(MAX_SNOOZE + 1) < 2) ? 2 : $clog2(MAX_SNOOZE + 1);
  logic [SCW-1:0] snz_cnt_q, snz_cnt_d;
  assign snooze_ok = (snz_cnt_q != SCW'(MAX_SNOOZE));
`else
  assign snooze_ok = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    al_hr_d    = al_hr_q;
    al_min_d   = al_min_q;
    tgt_hr_d   = tgt_hr_q;
    tgt_min_d  = tgt_min_q;
    ring_cnt_d = ring_cnt_q;
`ifdef SNOOZE_LIMIT_EN
    snz_cnt_d  = snz_cnt_q;
`endif

    if (set_en) begin
      al_hr_d  = set_hours;
      al_min_d = set_minutes;
      state_d  = IDLE;
    end else if (!alarm_on) begin
      state_d = IDLE;
    end else if (stop && (state_q != IDLE)) begin
      state_d = IDLE;
    end else if (snooze && (state_q == RINGING) && snooze_ok) begin
      state_d = SNOOZE;
      if (snz_sum >= 7'd60) begin
        tgt_min_d = 6'(snz_sum - 7'd60);
        tgt_hr_d  = (hours == 5'd23) ? 5'd0 : hours + 5'd1;
      end else begin
        tgt_min_d = snz_sum[5:0];
        tgt_hr_d  = hours;
      end
`ifdef SNOOZE_LIMIT_EN
      snz_cnt_d = snz_cnt_q + 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (hit_alarm) begin
            state_d    = RINGING;
            ring_cnt_d = 8'd0;
          end
        end
        RINGING: begin
          if (sec_edge) begin
            if (ring_cnt_q == 8'(RING_TIMEOUT_S - 1)) begin
              state_d = IDLE;
            end else begin
              ring_cnt_d = ring_cnt_q + 8'd1;
            end
          end
        end
        SNOOZE: begin
          if (hit_tgt) begin
            state_d    = RINGING;
            ring_cnt_d = 8'd0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

`ifdef SNOOZE_LIMIT_EN
    // A new alarm event starts with a fresh snooze allowance.
    if (state_d == IDLE) begin
      snz_cnt_d = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      sec_q      <= 6'd0;
      al_hr_q    <= 5'd0;
      al_min_q   <= 6'd0;
      tgt_hr_q   <= 5'd0;
      tgt_min_q  <= 6'd0;
      ring_cnt_q <= 8'd0;
      ring_q     <= 1'b0;
      snoozed_q  <= 1'b0;
`ifdef SNOOZE_LIMIT_EN
      snz_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sec_q      <= seconds;
      al_hr_q    <= al_hr_d;
      al_min_q   <= al_min_d;
      tgt_hr_q   <= tgt_hr_d;
      tgt_min_q  <= tgt_min_d;
      ring_cnt_q <= ring_cnt_d;
      ring_q     <= (state_d == RINGING);
      snoozed_q  <= (state_d == SNOOZE);
`ifdef SNOOZE_LIMIT_EN
      snz_cnt_q  <= snz_cnt_d;
`endif
    end
  end

  assign ring          = ring_q;
  assign snoozed       = snoozed_q;
  assign alarm_hours   = al_hr_q;
  assign alarm_minutes = al_min_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Testbench for alarm_ctrl: stimulus drives time and pulses, a reference model pushes expected
// outputs into a scoreboard queue, and a monitor pops and compares after every rising edge.
module tb_alarm_ctrl;

  localparam int SN = 5;
  localparam int TO = 60;
`ifdef SNOOZE_LIMIT_EN
  localparam int LIMIT = 3;
`else
  localparam int LIMIT = 1 << 30;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] seconds, minutes;
  logic [4:0] hours;
  logic       alarm_on, set_en, snooze, stop;
  logic [4:0] set_hours;
  logic [5:0] set_minutes;
  logic       ring, snoozed;
  logic [4:0] alarm_hours;
  logic [5:0] alarm_minutes;

  always #5 clk = ~clk;

  alarm_ctrl #(.SNOOZE_MIN(SN), .RING_TIMEOUT_S(TO)) dut (
    .clk(clk), .rst(rst), .seconds(seconds), .minutes(minutes), .hours(hours),
    .alarm_on(alarm_on), .set_en(set_en), .set_hours(set_hours), .set_minutes(set_minutes),
    .snooze(snooze), .stop(stop), .ring(ring), .snoozed(snoozed),
    .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes)
  );

  typedef struct {
    logic       ring;
    logic       snz;
    logic [4:0] ah;
    logic [5:0] am;
    string      tag;
    int         cyc;
  } exp_t;

  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  int    ncyc = 0;
  string phase = "reset";

  // Stimulus-side wall clock and controls.
  int ch = 0, cm = 0, cs = 0;
  int sh = 0, sm = 0;
  bit aon = 0;

  // Reference model: alarm event tracked as booleans plus elapsed second changes.
  bit m_ring, m_snz;
  int m_ah, m_am, m_th, m_tm, m_prev, m_secs, m_used;

  task automatic model(input bit r, input bit se, input bit sn, input bit st);
    bit edge_s;
    int tmin;
    if (!r) begin
      m_ring = 0; m_snz = 0; m_ah = 0; m_am = 0; m_th = 0; m_tm = 0;
      m_prev = 0; m_secs = 0; m_used = 0;
      return;
    end
    edge_s = (cs != m_prev);
    m_prev = cs;
    if (se) begin
      m_ah = sh; m_am = sm; m_ring = 0; m_snz = 0;
    end else if (!aon) begin
      m_ring = 0; m_snz = 0;
    end else if (st && (m_ring || m_snz)) begin
      m_ring = 0; m_snz = 0;
    end else if (sn && m_ring && m_used < LIMIT) begin
      m_ring = 0; m_snz = 1; m_used++;
      tmin = (ch * 60 + cm + SN) % 1440;
      m_th = tmin / 60; m_tm = tmin % 60;
    end else if (m_ring) begin
      if (edge_s) begin
        m_secs++;
        if (m_secs == TO) m_ring = 0;
      end
    end else if (m_snz) begin
      if (edge_s && cs == 0 && ch == m_th && cm == m_tm) begin
        m_snz = 0; m_ring = 1; m_secs = 0;
      end
    end else if (edge_s && cs == 0 && ch == m_ah && cm == m_am) begin
      m_ring = 1; m_secs = 0;
    end
    if (!m_ring && !m_snz) m_used = 0;
  endtask

  task automatic drive(input bit r, input bit se, input bit sn, input bit st);
    exp_t e;
    @(negedge clk);
    rst = r; set_en = se; snooze = sn; stop = st; alarm_on = aon;
    seconds = 6'(cs); minutes = 6'(cm); hours = 5'(ch);
    set_hours = 5'(sh); set_minutes = 6'(sm);
    model(r, se, sn, st);
    e.ring = m_ring; e.snz = m_snz; e.ah = 5'(m_ah); e.am = 6'(m_am);
    e.tag = phase; e.cyc = ncyc;
    ncyc++;
    sb.push_back(e);
  endtask

  task automatic set_time(input int h, input int m, input int s);
    ch = h; cm = m; cs = s;
  endtask

  task automatic adv();
    cs++;
    if (cs == 60) begin cs = 0; cm++; end
    if (cm == 60) begin cm = 0; ch++; end
    if (ch == 24) ch = 0;
  endtask

  // Advance n seconds, sometimes holding a second for an extra cycle.
  task automatic tick_sec(input int n);
    for (int i = 0; i < n; i++) begin
      adv();
      drive(1, 0, 0, 0);
      if ($urandom_range(0, 2) == 0) drive(1, 0, 0, 0);
    end
  endtask

  // Monitor: one comparison per presented output cycle.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (ring !== e.ring || snoozed !== e.snz || alarm_hours !== e.ah || alarm_minutes !== e.am) begin
        errors++;
        $display("FAIL %s cyc=%0d: got ring=%b snoozed=%b alarm=%0d:%0d, expected ring=%b snoozed=%b alarm=%0d:%0d",
                 e.tag, e.cyc, ring, snoozed, alarm_hours, alarm_minutes, e.ring, e.snz, e.ah, e.am);
      end
    end
  end

  // Watchdog: the test must finish well before this expires.
  initial begin
    #50_000_000;
    errors++;
    $display("FAIL watchdog expired in phase %s after %0d cycles", phase, ncyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    rst = 0; set_en = 0; snooze = 0; stop = 0; alarm_on = 0;
    seconds = 6'd17; minutes = 0; hours = 0; set_hours = 0; set_minutes = 0;
    set_time(0, 0, 17);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);

    // Explicit reset-state check.
    @(posedge clk);
    #2;
    checks++;
    if (ring !== 1'b0 || snoozed !== 1'b0 || alarm_hours !== 5'd0 || alarm_minutes !== 6'd0) begin
      errors++;
      $display("FAIL reset state: ring=%b snoozed=%b alarm=%0d:%0d", ring, snoozed, alarm_hours, alarm_minutes);
    end

    // Basic ring and timeout at 7:30.
    phase = "ring_timeout";
    aon = 1; sh = 7; sm = 30;
    set_time(7, 29, 55);
    drive(1, 1, 0, 0);
    tick_sec(80);

    // Snooze at 7:30:10, re-ring at 7:35:00.
    phase = "snooze_basic";
    set_time(7, 29, 58);
    drive(1, 0, 0, 0);
    tick_sec(12);
    drive(1, 0, 1, 0);
    tick_sec(300);
    drive(1, 0, 0, 1);

    // Midnight wrap of the snooze target.
    phase = "snooze_wrap";
    sh = 23; sm = 59;
    set_time(23, 58, 58);
    drive(1, 1, 0, 0);
    tick_sec(7);
    drive(1, 0, 1, 0);
    set_time(1, 3, 58);
    drive(1, 0, 0, 0);
    tick_sec(4);
    set_time(0, 3, 58);
    drive(1, 0, 0, 0);
    tick_sec(4);
    phase = "stop_and_snooze";
    drive(1, 0, 1, 1);
    tick_sec(3);

    // Held at hh:mm:00: single trigger, no retrigger after stop.
    phase = "hold_edge";
    sh = 12; sm = 0;
    set_time(11, 59, 59);
    drive(1, 1, 0, 0);
    set_time(12, 0, 0);
    repeat (3) drive(1, 0, 0, 0);
    drive(1, 0, 0, 1);
    repeat (3) drive(1, 0, 0, 0);

    // alarm_on dropped mid-ring.
    phase = "alarm_off";
    set_time(11, 59, 59);
    drive(1, 0, 0, 0);
    set_time(12, 0, 0);
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    aon = 0;
    drive(1, 0, 0, 0);
    aon = 1;
    repeat (2) drive(1, 0, 0, 0);

    // Reset mid-ring clears alarm time; alarm off passes 7:30 silently.
    phase = "reset_mid_ring";
    set_time(11, 59, 59);
    drive(1, 0, 0, 0);
    set_time(12, 0, 0);
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    aon = 0;
    set_time(7, 29, 58);
    drive(1, 0, 0, 0);
    tick_sec(4);

    // set_en during SNOOZE cancels the event.
    phase = "set_cancels";
    aon = 1; sh = 7; sm = 30;
    set_time(7, 29, 59);
    drive(1, 1, 0, 0);
    tick_sec(2);
    drive(1, 0, 1, 0);
    drive(1, 1, 0, 0);
    set_time(7, 34, 58);
    drive(1, 0, 0, 0);
    tick_sec(4);

    // Repeated snoozes (four attempts), then let it time out.
    phase = "snooze_repeat";
    set_time(7, 29, 58);
    drive(1, 0, 0, 0);
    tick_sec(3);
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 1, 0);
      set_time(7, 34 + 5 * k, 58);
      drive(1, 0, 0, 0);
      tick_sec(4);
    end
    tick_sec(70);
    drive(1, 0, 0, 1);

    // Randomised traffic around the current time.
    phase = "random";
    set_time(9, 58, 0);
    for (int i = 0; i < 3000; i++) begin
      int r;
      bit p_set, p_snz, p_stp, p_rst;
      r = $urandom_range(0, 999);
      p_set = (r < 20);
      p_snz = (r >= 20 && r < 60);
      p_stp = (r >= 60 && r < 80);
      p_rst = (r >= 80 && r < 85);
      if (r >= 85 && r < 95) aon = ~aon;
      if (r >= 95 && r < 100) aon = 1;
      if (p_set) begin
        if ($urandom_range(0, 9) == 0) begin
          sh = $urandom_range(0, 31); sm = $urandom_range(0, 63);
        end else begin
          sh = ch; sm = (cm + $urandom_range(0, 2)) % 60;
        end
      end
      if ($urandom_range(0, 9) < 7) adv();
      drive(!p_rst, p_set, p_snz, p_stp);
    end

    phase = "drain";
    drive(1, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries never compared", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
